// File: rtl/reading_sequencer.sv
// Three-digit BCD entry sequencer: one digit per key press, commit shifts current->previous, and pages the display.
// Build option SIGN_EN enables sign capture with negative-zero normalisation; without it both signs are tied to 0.
module reading_sequencer #(
  parameter int PAGE_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_press,
  input  logic [3:0] bcd_num,
  input  logic       sign_in,
  output logic [1:0] digit_idx,
  output logic [3:0] cur_ones,
  output logic [3:0] cur_tens,
  output logic [3:0] cur_huns,
  output logic [3:0] prev_ones,
  output logic [3:0] prev_tens,
  output logic [3:0] prev_huns,
  output logic       cur_sign,
  output logic       prev_sign,
  output logic       commit,
  output logic       page,
  output logic       err
);

  localparam int CW = $clog2(PAGE_CYCLES);

  typedef enum logic [2:0] {ST_ONES, ST_TENS, ST_HUNS, ST_COMMIT, ST_SHOW} state_t;

  state_t          state_q, state_d;
  logic            key_q;
  logic [3:0]      ent_ones_q, ent_ones_d, ent_tens_q, ent_tens_d;
  logic [11:0]     cur_q, cur_d, prev_q, prev_d;
  logic            commit_q, commit_d, page_q, page_d, err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            press, valid, vpress;

  assign press  = key_press & ~key_q;
  assign valid  = (bcd_num <= 4'd9);
  assign vpress = press & valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_ONES;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ONES:   if (vpress) state_d = ST_TENS;
      ST_TENS:   if (vpress) state_d = ST_HUNS;
      ST_HUNS:   if (vpress) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_SHOW;
      ST_SHOW:   if (vpress) state_d = ST_TENS;
      default:   state_d = ST_ONES;
    endcase
  end

  always_comb begin
    case (state_q)
      ST_ONES: digit_idx = 2'd0;
      ST_TENS: digit_idx = 2'd1;
      ST_HUNS: digit_idx = 2'd2;
      default: digit_idx = 2'd3;
    endcase
  end

  // The operand transfer happens on the hundreds press edge, so the commit
  // pulse and the new (previous, current) pair are both visible in the COMMIT cycle.
  always_comb begin
    ent_ones_d = ent_ones_q;
    ent_tens_d = ent_tens_q;
    cur_d      = cur_q;
    prev_d     = prev_q;
    commit_d   = 1'b0;
    err_d      = err_q;
    if (press && state_q != ST_COMMIT) err_d = ~valid;
    if (vpress) begin
      case (state_q)
        ST_ONES, ST_SHOW: ent_ones_d = bcd_num;
        ST_TENS:          ent_tens_d = bcd_num;
        ST_HUNS: begin
          prev_d   = cur_q;
          cur_d    = {bcd_num, ent_tens_q, ent_ones_q};
          commit_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cnt_d  = '0;
    page_d = 1'b0;
    if (state_q == ST_SHOW && state_d == ST_SHOW) begin
      if (cnt_q == CW'(PAGE_CYCLES - 1)) begin
        page_d = ~page_q;
      end else begin
        cnt_d  = cnt_q + CW'(1);
        page_d = page_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_q      <= 1'b0;
      ent_ones_q <= '0;
      ent_tens_q <= '0;
      cur_q      <= '0;
      prev_q     <= '0;
      commit_q   <= 1'b0;
      page_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      key_q      <= key_press;
      ent_ones_q <= ent_ones_d;
      ent_tens_q <= ent_tens_d;
      cur_q      <= cur_d;
      prev_q     <= prev_d;
      commit_q   <= commit_d;
      page_q     <= page_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef SIGN_EN
  logic cur_sign_q, cur_sign_d, prev_sign_q, prev_sign_d;

  // A reading of 000 is always stored as positive.
  always_comb begin
    cur_sign_d  = cur_sign_q;
    prev_sign_d = prev_sign_q;
    if (vpress && state_q == ST_HUNS) begin
      prev_sign_d = cur_sign_q;
      cur_sign_d  = sign_in & (|{bcd_num, ent_tens_q, ent_ones_q});
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_sign_q  <= 1'b0;
      prev_sign_q <= 1'b0;
    end else begin
      cur_sign_q  <= cur_sign_d;
      prev_sign_q <= prev_sign_d;
    end
  end

  assign cur_sign  = cur_sign_q;
  assign prev_sign = prev_sign_q;
`else
  logic unused_sign;
  assign unused_sign = sign_in;
  assign cur_sign    = 1'b0;
  assign prev_sign   = 1'b0;
`endif

  assign {cur_huns, cur_tens, cur_ones}    = cur_q;
  assign {prev_huns, prev_tens, prev_ones} = prev_q;
  assign commit = commit_q;
  assign page   = page_q;
  assign err    = err_q;

endmodule
